ci_response_collector: RTL and testbench



---
 rtl/ci_response_collector.sv | 145 ++++++++++++++
 tb/tb_ci_response_collector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ci_response_collector.sv
// Merges custom-instruction slave responses into one CPU response, with a watchdog timeout.
// Optional CI_COLLECTOR_STATUS_EN adds a status instruction exposing collision/timeout diagnostics.
module ci_response_collector #(
  parameter int unsigned NR_OF_SLAVES   = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [7:0]  STATUS_CI_NR   = 8'hFF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [7:0]                   ci_n_i,
  input  logic [31:0]                  ci_data_b_i,
  input  logic                         ci_start_i,
  input  logic                         ci_cke_i,
  input  logic [NR_OF_SLAVES-1:0]      slave_done_i,
  input  logic [32*NR_OF_SLAVES-1:0]   slave_results_i,
  output logic                         ci_done_o,
  output logic [31:0]                  ci_result_o,
  output logic                         busy_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] TIMEOUT_RESULT = 32'hDEADDEAD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   timeout_count_q, timeout_count_d;
  logic               collision_q, collision_d;

  logic               any_done;
  logic               multi_done;
  logic [31:0]        merged_result;
  logic               status_hit;

  // OR-merge of all slave channels plus detection of more than one responder
  always_comb begin
    logic seen;
    seen          = 1'b0;
    multi_done    = 1'b0;
    merged_result = 32'd0;
    for (int unsigned i = 0; i < NR_OF_SLAVES; i++) begin
      multi_done    = multi_done | (seen & slave_done_i[i]);
      seen          = seen | slave_done_i[i];
      merged_result = merged_result | slave_results_i[32*i +: 32];
    end
    any_done = seen;
  end

`ifdef CI_COLLECTOR_STATUS_EN
  assign status_hit = (ci_n_i == STATUS_CI_NR);
  logic unused_bits;
  assign unused_bits = ^ci_data_b_i[31:1];
`else
  assign status_hit = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{ci_data_b_i, ci_n_i, STATUS_CI_NR, status_hit};
`endif

  assign busy_o = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      timeout_count_q <= '0;
      collision_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      timeout_count_q <= timeout_count_d;
      collision_q     <= collision_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    timeout_count_d = timeout_count_q;
    collision_d     = collision_q;
    ci_done_o       = 1'b0;
    ci_result_o     = 32'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (ci_start_i && ci_cke_i) begin
`ifdef CI_COLLECTOR_STATUS_EN
          // Status read; a clear wins over any coincident flag update
          if (status_hit) begin
            ci_done_o   = 1'b1;
            ci_result_o = {collision_q, 15'd0, timeout_count_q} | merged_result;
            if (any_done) collision_d = 1'b1;
            if (ci_data_b_i[0]) begin
              collision_d     = 1'b0;
              timeout_count_d = '0;
            end
          end else
`endif
          if (any_done) begin
            ci_done_o   = 1'b1;
            ci_result_o = merged_result;
            if (multi_done) collision_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      ST_WAIT: begin
        if (ci_cke_i) begin
          if (any_done) begin
            ci_done_o   = 1'b1;
            ci_result_o = merged_result;
            if (multi_done) collision_d = 1'b1;
            state_d     = ST_IDLE;
            cnt_d       = '0;
          end else if (cnt_q == TIMEOUT_CYCLES) begin
            state_d = ST_TIMEOUT;
            cnt_d   = '0;
            if (timeout_count_q != 16'hFFFF) timeout_count_d = timeout_count_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_TIMEOUT: begin
        ci_done_o   = 1'b1;
        ci_result_o = TIMEOUT_RESULT;
        if (ci_cke_i) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ci_response_collector.sv
// Randomized + directed bench for ci_response_collector against a transaction-level model.
module tb_ci_response_collector;

  localparam int unsigned NS   = 4;
  localparam int          TOUT = 8;
  localparam logic [7:0]  STAT = 8'hFF;
`ifdef CI_COLLECTOR_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [7:0]        ci_n_i;
  logic [31:0]       ci_data_b_i;
  logic              ci_start_i;
  logic              ci_cke_i;
  logic [NS-1:0]     slave_done_i;
  logic [32*NS-1:0]  slave_results_i;
  logic              ci_done_o;
  logic [31:0]       ci_result_o;
  logic              busy_o;

  ci_response_collector #(
    .NR_OF_SLAVES  (NS),
    .TIMEOUT_CYCLES(16'(TOUT)),
    .STATUS_CI_NR  (STAT)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ci_n_i         (ci_n_i),
    .ci_data_b_i    (ci_data_b_i),
    .ci_start_i     (ci_start_i),
    .ci_cke_i       (ci_cke_i),
    .slave_done_i   (slave_done_i),
    .slave_results_i(slave_results_i),
    .ci_done_o      (ci_done_o),
    .ci_result_o    (ci_result_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: outstanding request, its qualified-cycle index, pending forced reply
  bit m_wait, m_to, m_coll;
  int m_idx, m_tocnt;

  logic        obs_done, obs_busy;
  logic [31:0] obs_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_to = 0; m_coll = 0; m_idx = 0; m_tocnt = 0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, return at next posedge+1
  task automatic step(input bit start, input logic [7:0] n, input logic [31:0] b, input bit cke,
                      input logic [NS-1:0] dn, input logic [32*NS-1:0] res_in);
    logic [32*NS-1:0] res;
    logic [31:0] merged, e_res;
    bit any, multi, e_done, e_busy, skip;
    res = '0;
    for (int i = 0; i < NS; i++) if (dn[i]) res[32*i +: 32] = res_in[32*i +: 32];
    ci_start_i = start; ci_n_i = n; ci_data_b_i = b; ci_cke_i = cke;
    slave_done_i = dn; slave_results_i = res;
    #4;
    merged = 32'd0;
    for (int i = 0; i < NS; i++) merged |= res[32*i +: 32];
    any = (dn != '0);
    multi = ($countones(dn) > 1);
    e_done = 0; e_res = 32'd0; e_busy = m_wait || m_to; skip = 0;
    if (m_to) begin
      if (cke) begin e_done = 1; e_res = 32'hDEADDEAD; m_to = 0; end
      else skip = 1;
    end else if (m_wait) begin
      if (cke) begin
        if (any) begin
          e_done = 1; e_res = merged; m_wait = 0;
          if (multi) m_coll = 1;
        end else if (m_idx == TOUT) begin
          m_wait = 0; m_to = 1;
          if (m_tocnt < 65535) m_tocnt++;
        end else m_idx++;
      end
    end else if (start && cke) begin
      if (STAT_EN && n == STAT) begin
        e_done = 1;
        e_res = {m_coll, 15'd0, 16'(m_tocnt)} | merged;
        if (any) m_coll = 1;
        if (b[0]) begin m_coll = 0; m_tocnt = 0; end
      end else if (any) begin
        e_done = 1; e_res = merged;
        if (multi) m_coll = 1;
      end else begin
        m_wait = 1; m_idx = 1;
      end
    end
    obs_done = ci_done_o; obs_res = ci_result_o; obs_busy = busy_o;
    chk("busy", 32'(busy_o), 32'(e_busy));
    if (!skip) begin
      chk("done", 32'(ci_done_o), 32'(e_done));
      chk("result", ci_result_o, e_res);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle_step();
    step(0, 8'h00, 32'd0, 1, '0, '0);
  endtask

  task automatic flush();
    for (int i = 0; i < 40 && (m_wait || m_to); i++) idle_step();
    if (m_wait || m_to) chk("flush_timeout", 32'd1, 32'd0);
  endtask

  task automatic status_read(input logic [31:0] b);
    step(1, STAT, b, 1, '0, '0);
  endtask

  initial begin
    int qcnt;
    bit seen;
    rst_i = 1; ci_n_i = 0; ci_data_b_i = 0; ci_start_i = 0; ci_cke_i = 0;
    slave_done_i = '0; slave_results_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_done", 32'(ci_done_o), 32'd0);
    chk("rst_result", ci_result_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 0;
    @(posedge clk_i); #1;

    // Reset asserted while waiting
    step(1, 8'h10, 32'd0, 1, '0, '0);
    repeat (4) idle_step();
    #1 rst_i = 1;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(ci_done_o), 32'd0);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 0;
    idle_step();
    chk("post_rst_busy", 32'(obs_busy), 32'd0);
`ifdef CI_COLLECTOR_STATUS_EN
    status_read(32'd0);
    chk("post_rst_status", obs_res, 32'h0);
`endif
    flush();

    // Zero-latency response
    step(1, 8'h01, 32'd0, 1, 4'b0001, {96'd0, 32'h44332211});
    chk("zl_done", 32'(obs_done), 32'd1);
    chk("zl_result", obs_res, 32'h44332211);
    chk("zl_busy", 32'(obs_busy), 32'd0);

    // Slave 2 answers on 3rd qualified cycle with cke gaps (stray done while cke low)
    step(1, 8'h02, 32'd0, 1, '0, '0);
    idle_step();
    step(0, 8'h00, 32'd0, 0, 4'b0100, {32'd0, 32'h12345678, 64'd0});
    chk("cke_low_done", 32'(obs_done), 32'd0);
    step(0, 8'h00, 32'd0, 0, '0, '0);
    idle_step();
    step(0, 8'h00, 32'd0, 1, 4'b0100, {32'd0, 32'hCAFEF00D, 64'd0});
    chk("late_done", 32'(obs_done), 32'd1);
    chk("late_result", obs_res, 32'hCAFEF00D);
    idle_step();
    chk("late_idle", 32'(obs_busy), 32'd0);

    // Timeout on unused instruction number
    step(1, 8'h10, 32'd0, 1, '0, '0);
    qcnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle_step();
      qcnt++;
      if (obs_done) seen = 1;
    end
    chk("to_cycle", 32'(qcnt), 32'(TOUT + 1));
    chk("to_result", obs_res, 32'hDEADDEAD);
`ifdef CI_COLLECTOR_STATUS_EN
    status_read(32'd0);
    chk("to_status", obs_res, 32'h00000001);
`endif
    flush();

    // Collision
    step(1, 8'h03, 32'd0, 1, 4'b0011, {64'd0, 32'h000000F0, 32'h0000000F});
    chk("coll_result", obs_res, 32'h000000FF);
`ifdef CI_COLLECTOR_STATUS_EN
    status_read(32'd0);
    chk("coll_status", obs_res, 32'h80000001);
    status_read(32'd1);
    status_read(32'd0);
    chk("cleared_status", obs_res, 32'h0);
`endif
    flush();

    // Stray done in idle
    step(0, 8'h05, 32'd0, 1, 4'b1010, {32'h1, 32'h0, 32'h2, 32'h0});
    chk("stray_done", 32'(obs_done), 32'd0);
    chk("stray_busy", 32'(obs_busy), 32'd0);
`ifdef CI_COLLECTOR_STATUS_EN
    status_read(32'd0);
    chk("stray_status", obs_res, 32'h0);
`endif
    flush();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [NS-1:0] dn;
      logic [7:0] n;
      for (int j = 0; j < NS; j++) dn[j] = ($urandom % 20 == 0);
      n = ($urandom % 4 == 0) ? STAT : 8'($urandom);
      step(($urandom % 3 == 0), n, $urandom, ($urandom % 5 != 0), dn,
           {$urandom, $urandom, $urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
